// File: rtl/calculator_core_pkg.sv
// Shared types and helpers for the calculator core.
package calc_pkg;

   localparam logic [31:0] MAX_ENTRY_DEFAULT = 32'd99_999_999;

   typedef enum logic [2:0] {
      OP_NONE = 3'b000,
      OP_EQ   = 3'b001,
      OP_ADD  = 3'b010,
      OP_SUB  = 3'b011,
      OP_MUL  = 3'b100,
      OP_DIV  = 3'b101,
      OP_CE   = 3'b110,
      OP_AC   = 3'b111
   } opcode_t;

   typedef enum logic [1:0] {
      ST_ENTER1,
      ST_ENTER2,
      ST_RESULT
   } state_t;

   function automatic logic is_onehot10(input logic [9:0] v);
      return (v != '0) && ((v & (v - 10'd1)) == '0);
   endfunction

   function automatic logic [3:0] onehot_to_digit(input logic [9:0] v);
      logic [3:0] d;
      d = '0;
      for (int unsigned i = 0; i < 10; i++) begin
         if (v[i]) d = 4'(i);
      end
      return d;
   endfunction

endpackage

// File: rtl/calculator_core_if.sv
// Keypad-side inputs and display/debug outputs of the calculator core.
interface calculator_core_if;
   logic        pwr;
   logic [2:0]  opcode;
   logic [9:0]  btn;
   logic [31:0] displayedNum;
   logic        num;
   logic        op;
   logic [31:0] val1;
   logic [31:0] val2;

   modport master (
      output pwr, opcode, btn,
      input  displayedNum, num, op, val1, val2
   );

   modport slave (
      input  pwr, opcode, btn,
      output displayedNum, num, op, val1, val2
   );
endinterface

// File: rtl/calculator_core_alu.sv
// Combinational 32-bit unsigned arithmetic; divide by zero yields zero.
module calc_alu
   import calc_pkg::*;
(
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  opcode_t     op,
   output logic [31:0] y
);

   // Select the pending operation; results wrap modulo 2^32.
   always_comb begin
      y = '0;
      case (op)
         OP_ADD:  y = a + b;
         OP_SUB:  y = a - b;
         OP_MUL:  y = a * b;
         OP_DIV:  y = (b == '0) ? '0 : a / b;
         default: y = '0;
      endcase
   end

endmodule

// File: rtl/calculator_core.sv
// Calculator core: key edge detection, entry FSM, operand registers.
module calculator_core
   import calc_pkg::*;
#(
   parameter logic [31:0] MAX_ENTRY = MAX_ENTRY_DEFAULT
) (
   input logic clk,
   input logic rst_n,
   calculator_core_if.slave bus
);

   logic [9:0]  btn_q, btn_qq;
   logic [2:0]  opc_q, opc_qq;
   state_t      state_r, state_nx;
   opcode_t     pend_r, pend_nx;
   logic [31:0] val1_r, val1_nx, val2_r, val2_nx, disp_r, disp_nx;
   logic        num_r, num_nx, op_r, op_nx;
   logic        op_ev, dig_ev;
   opcode_t     key_op;
   logic [3:0]  key_digit;
   logic [31:0] entry, alu_y;
   logic [35:0] acc;

   assign op_ev     = (opc_qq == 3'b000) && (opc_q != 3'b000);
   assign dig_ev    = (btn_qq == '0) && is_onehot10(btn_q);
   assign key_op    = opcode_t'(opc_q);
   assign key_digit = onehot_to_digit(btn_q);
   assign entry     = (state_r == ST_ENTER2) ? val2_r : val1_r;
   assign acc       = ({4'b0, entry} * 36'd10) + {32'b0, key_digit};

   calc_alu u_alu (
      .a  (val1_r),
      .b  (val2_r),
      .op (pend_r),
      .y  (alu_y)
   );

   assign bus.displayedNum = disp_r;
   assign bus.num          = num_r;
   assign bus.op           = op_r;
   assign bus.val1         = val1_r;
   assign bus.val2         = val2_r;

   // Key events and FSM transitions; an op event suppresses a same-cycle digit.
   always_comb begin
      state_nx = state_r;
      pend_nx  = pend_r;
      val1_nx  = val1_r;
      val2_nx  = val2_r;
      disp_nx  = disp_r;
      num_nx   = num_r;
      op_nx    = op_r;
      if (op_ev) begin
         case (key_op)
            OP_AC: begin
               state_nx = ST_ENTER1;
               pend_nx  = OP_NONE;
               val1_nx  = '0;
               val2_nx  = '0;
               disp_nx  = '0;
               num_nx   = 1'b0;
               op_nx    = 1'b0;
            end
            OP_CE: begin
               if (state_r == ST_ENTER2) val2_nx = '0;
               else                      val1_nx = '0;
               num_nx  = 1'b0;
               disp_nx = '0;
            end
            OP_EQ: begin
               if (state_r == ST_ENTER2 && num_r) begin
                  val1_nx  = alu_y;
                  disp_nx  = alu_y;
                  op_nx    = 1'b0;
                  num_nx   = 1'b0;
                  state_nx = ST_RESULT;
               end
            end
            OP_ADD, OP_SUB, OP_MUL, OP_DIV: begin
               pend_nx = key_op;
               if (state_r == ST_ENTER2) begin
                  // Chained operator: fold the completed pair into val1 first.
                  if (num_r) begin
                     val1_nx = alu_y;
                     disp_nx = alu_y;
                     val2_nx = '0;
                     num_nx  = 1'b0;
                  end
               end else begin
                  op_nx    = 1'b1;
                  val2_nx  = '0;
                  num_nx   = 1'b0;
                  state_nx = ST_ENTER2;
               end
            end
            default: ;
         endcase
      end else if (dig_ev) begin
         if (state_r == ST_RESULT) begin
            val1_nx  = {28'b0, key_digit};
            disp_nx  = {28'b0, key_digit};
            num_nx   = 1'b1;
            state_nx = ST_ENTER1;
         end else if (acc <= {4'b0, MAX_ENTRY}) begin
            if (state_r == ST_ENTER2) val2_nx = acc[31:0];
            else                      val1_nx = acc[31:0];
            disp_nx = acc[31:0];
            num_nx  = 1'b1;
         end
      end
   end

   // Input edge registers and architectural state; pwr clears everything.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         btn_q   <= '0;
         btn_qq  <= '0;
         opc_q   <= '0;
         opc_qq  <= '0;
         state_r <= ST_ENTER1;
         pend_r  <= OP_NONE;
         val1_r  <= '0;
         val2_r  <= '0;
         disp_r  <= '0;
         num_r   <= 1'b0;
         op_r    <= 1'b0;
      end else if (bus.pwr) begin
         btn_q   <= '0;
         btn_qq  <= '0;
         opc_q   <= '0;
         opc_qq  <= '0;
         state_r <= ST_ENTER1;
         pend_r  <= OP_NONE;
         val1_r  <= '0;
         val2_r  <= '0;
         disp_r  <= '0;
         num_r   <= 1'b0;
         op_r    <= 1'b0;
      end else begin
         btn_q   <= bus.btn;
         btn_qq  <= btn_q;
         opc_q   <= bus.opcode;
         opc_qq  <= opc_q;
         state_r <= state_nx;
         pend_r  <= pend_nx;
         val1_r  <= val1_nx;
         val2_r  <= val2_nx;
         disp_r  <= disp_nx;
         num_r   <= num_nx;
         op_r    <= op_nx;
      end
   end

endmodule

// File: tb/tb_calculator_core.sv
// Self-checking bench for calculator_core: behavioural model plus directed and random keys.
module tb_calculator_core;

   localparam bit [2:0] K_EQ  = 3'd1;
   localparam bit [2:0] K_ADD = 3'd2;
   localparam bit [2:0] K_SUB = 3'd3;
   localparam bit [2:0] K_MUL = 3'd4;
   localparam bit [2:0] K_DIV = 3'd5;
   localparam bit [2:0] K_CE  = 3'd6;
   localparam bit [2:0] K_AC  = 3'd7;
   localparam longint   MAXV  = 99_999_999;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

   calculator_core_if bus ();

   calculator_core #(.MAX_ENTRY(32'd99_999_999)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural model state: phase 0 = typing first number, 1 = typing second, 2 = showing result
   logic [31:0] m_v1, m_v2, m_disp;
   logic        m_num, m_op;
   int          phase;
   logic [2:0]  m_pend;
   logic [9:0]  h_btn1, h_btn2;
   logic [2:0]  h_opc1, h_opc2;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%08h expected=0x%08h at %0t", name, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] arith(input logic [31:0] a, input logic [31:0] b, input logic [2:0] o);
      longint unsigned la, lb;
      la = a;
      lb = b;
      case (o)
         K_ADD:   return 32'((la + lb) % 64'h1_0000_0000);
         K_SUB:   return 32'((la + 64'h1_0000_0000 - lb) % 64'h1_0000_0000);
         K_MUL:   return 32'((la * lb) % 64'h1_0000_0000);
         K_DIV:   return (lb == 0) ? 32'd0 : 32'(la / lb);
         default: return 32'd0;
      endcase
   endfunction

   task automatic m_clear();
      m_v1 = 0; m_v2 = 0; m_disp = 0; m_num = 0; m_op = 0; phase = 0; m_pend = 0;
   endtask

   task automatic m_operator(input logic [2:0] o);
      logic [31:0] r;
      if (o == K_AC) m_clear();
      else if (o == K_CE) begin
         if (phase == 1) m_v2 = 0; else m_v1 = 0;
         m_num = 0; m_disp = 0;
      end else if (o == K_EQ) begin
         if (phase == 1 && m_num) begin
            r = arith(m_v1, m_v2, m_pend);
            m_v1 = r; m_disp = r; m_op = 0; m_num = 0; phase = 2;
         end
      end else if (phase == 1) begin
         if (m_num) begin
            r = arith(m_v1, m_v2, m_pend);
            m_v1 = r; m_disp = r; m_v2 = 0; m_num = 0;
         end
         m_pend = o;
      end else begin
         m_pend = o; m_op = 1; m_v2 = 0; m_num = 0; phase = 1;
      end
   endtask

   task automatic m_digit(input int d);
      longint nv;
      if (phase == 2) begin
         m_v1 = d; m_disp = d; m_num = 1; phase = 0;
      end else begin
         nv = longint'(phase == 1 ? m_v2 : m_v1) * 10 + d;
         if (nv <= MAXV) begin
            if (phase == 1) m_v2 = 32'(nv); else m_v1 = 32'(nv);
            m_disp = 32'(nv); m_num = 1;
         end
      end
   endtask

   // Model advances on each clock using keys seen one and two cycles ago
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_clear();
         h_btn1 = 0; h_btn2 = 0; h_opc1 = 0; h_opc2 = 0;
      end else if (bus.pwr) begin
         m_clear();
         h_btn1 = 0; h_btn2 = 0; h_opc1 = 0; h_opc2 = 0;
      end else begin
         if (h_opc2 == 0 && h_opc1 != 0) m_operator(h_opc1);
         else if (h_btn2 == 0 && $countones(h_btn1) == 1) begin
            for (int i = 0; i < 10; i++) if (h_btn1[i]) m_digit(i);
         end
         h_btn2 = h_btn1; h_opc2 = h_opc1;
         h_btn1 = bus.btn; h_opc1 = bus.opcode;
      end
   end

   // Compare every output against the model on each falling edge
   always @(negedge clk) begin
      if (rst_n) begin
         chk("displayedNum", bus.displayedNum, m_disp);
         chk("num", {31'b0, bus.num}, {31'b0, m_num});
         chk("op", {31'b0, bus.op}, {31'b0, m_op});
         chk("val1", bus.val1, m_v1);
         chk("val2", bus.val2, m_v2);
      end
   end

   task automatic key(input bit is_op, input int v, input int hold, input int gap);
      @(negedge clk);
      if (is_op) bus.opcode = 3'(v);
      else       bus.btn = 10'b1 << v;
      repeat (hold) @(negedge clk);
      bus.opcode = 0;
      bus.btn = 0;
      repeat (gap) @(negedge clk);
   endtask

   task automatic dig(input int d);
      key(1'b0, d, 1, 3);
   endtask

   task automatic opk(input int o);
      key(1'b1, o, 1, 3);
   endtask

   task automatic lit(input string name, input logic [31:0] dut_v, input logic [31:0] mdl_v, input logic [31:0] exp);
      chk({name, "_dut"}, dut_v, exp);
      chk({name, "_model"}, mdl_v, exp);
   endtask

   initial begin
      int r;
      checks = 0;
      failures = 0;
      rst_n = 1'b0;
      bus.pwr = 0;
      bus.opcode = 0;
      bus.btn = 0;
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      lit("reset_disp", bus.displayedNum, m_disp, 32'd0);
      lit("reset_val1", bus.val1, m_v1, 32'd0);
      @(negedge clk) bus.pwr = 1;
      @(negedge clk) bus.pwr = 0;
      @(negedge clk);
      lit("pwr_num", {31'b0, bus.num}, {31'b0, m_num}, 32'd0);
      lit("pwr_op", {31'b0, bus.op}, {31'b0, m_op}, 32'd0);

      key(1'b0, 5, 10, 3);
      key(1'b1, K_ADD, 10, 3);
      dig(3);
      opk(K_EQ);
      lit("add_disp", bus.displayedNum, m_disp, 32'd8);
      lit("add_val1", bus.val1, m_v1, 32'd8);
      lit("add_op", {31'b0, bus.op}, {31'b0, m_op}, 32'd0);

      dig(1); dig(2); dig(3); opk(K_SUB); dig(5); opk(K_EQ);
      lit("sub_disp", bus.displayedNum, m_disp, 32'd118);
      dig(2); opk(K_SUB); dig(5); opk(K_EQ);
      lit("sub_wrap", bus.displayedNum, m_disp, 32'hFFFF_FFFD);

      dig(6); opk(K_MUL); dig(7); opk(K_ADD);
      lit("chain_disp", bus.displayedNum, m_disp, 32'd42);
      lit("chain_op", {31'b0, bus.op}, {31'b0, m_op}, 32'd1);
      dig(8); opk(K_EQ);
      lit("chain_res", bus.displayedNum, m_disp, 32'd50);

      dig(9); opk(K_DIV); dig(0); opk(K_EQ);
      lit("div0", bus.displayedNum, m_disp, 32'd0);
      dig(9); opk(K_DIV); dig(2); opk(K_EQ);
      lit("div_trunc", bus.displayedNum, m_disp, 32'd4);

      dig(7); opk(K_ADD); dig(4); opk(K_CE);
      lit("ce_disp", bus.displayedNum, m_disp, 32'd0);
      lit("ce_op", {31'b0, bus.op}, {31'b0, m_op}, 32'd1);
      dig(5); opk(K_EQ);
      lit("ce_res", bus.displayedNum, m_disp, 32'd12);

      repeat (9) dig(9);
      lit("max_entry", bus.displayedNum, m_disp, 32'd99_999_999);
      @(negedge clk) bus.pwr = 1;
      @(negedge clk) bus.pwr = 0;
      @(negedge clk);
      lit("pwr_mid_val1", bus.val1, m_v1, 32'd0);

      dig(3); dig(4);
      lit("entry34", bus.displayedNum, m_disp, 32'd34);
      @(negedge clk) bus.btn = 10'b1 << 6;
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      lit("async_disp", bus.displayedNum, m_disp, 32'd0);
      lit("async_val1", bus.val1, m_v1, 32'd0);
      chk("async_num", {31'b0, bus.num}, 32'd0);
      @(negedge clk) bus.btn = 0;
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;
      repeat (2) @(negedge clk);

      for (int it = 0; it < 400; it++) begin
         r = $urandom_range(0, 99);
         if (r < 50) key(1'b0, $urandom_range(0, 9), $urandom_range(1, 3), $urandom_range(1, 3));
         else if (r < 80) key(1'b1, $urandom_range(1, 5), $urandom_range(1, 3), $urandom_range(1, 3));
         else if (r < 85) key(1'b1, K_CE, 1, 2);
         else if (r < 87) key(1'b1, K_AC, 2, 2);
         else if (r < 92) begin
            @(negedge clk);
            bus.btn = 10'b1 << $urandom_range(0, 9);
            bus.opcode = 3'($urandom_range(1, 5));
            @(negedge clk);
            bus.btn = 0; bus.opcode = 0;
            repeat (2) @(negedge clk);
         end else if (r < 96) begin
            @(negedge clk) bus.btn = 10'b0000_1000_01 | (10'b1 << $urandom_range(6, 9));
            @(negedge clk) bus.btn = 0;
            repeat (2) @(negedge clk);
         end else begin
            @(negedge clk) bus.pwr = 1;
            @(negedge clk) bus.pwr = 0;
         end
      end
      repeat (4) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
